ysyx_2022040010_regfile: RTL and testbench
==========================================

YSYX_2022040010_REGFILE -- requirements
Module: ysyx_2022040010_regfile

Interface
REQ-001 SHALL have parameter XLEN, 64, register width.
REQ-002 SHALL have parameter NREG, 32, architectural register count.
REQ-003 SHALL have parameter PEND_W, 2, pending-counter width (max 3 in-flight writers per register).
REQ-004 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wb_to_rf_bus  in  70  writeback bus {we[69], waddr[68:64], wdata[63:0]}.
REQ-007 SHALL have ports rs1_addr, rs2_addr  in  5 each  ID read addresses.
REQ-008 SHALL have ports rs1_data, rs2_data  out  XLEN each  read data.
REQ-009 SHALL have ports rs1_busy, rs2_busy  out  1 each  RAW hazard flags to ID stall logic.
REQ-010 SHALL have ports issue_fire  in  1, issue_we  in  1, issue_waddr  in  5  ID issue of a register-writing instruction.
REQ-011 SHALL have port sb_clear  in  1  synchronous clear of all pending counters (pipeline drained/flushed).
REQ-012 SHALL have ports dbg_addr  in  5, dbg_data  out  XLEN  debug/difftest read port.
REQ-013 SHALL have port pend_err  out  1  sticky counter overflow/underflow flag.
REQ-014 SHALL have port wr_cnt  out  32  count of committed register writes.

Function
REQ-015 SHALL write regs[waddr] <= wdata on rising clk when we=1 and waddr!=0; waddr=0 writes are dropped.
REQ-016 SHALL return 0 for any read of x0 on all read ports, regardless of writes.
REQ-017 SHALL read rs1/rs2/dbg combinationally (zero latency).
REQ-018 SHALL bypass rs1_data/rs2_data to wdata when we=1, waddr==rsX_addr, rsX_addr!=0 (write-first); dbg_data SHALL NOT bypass.
REQ-019 SHALL keep one PEND_W-bit pending counter per register 1..31; x0 has none.
REQ-020 SHALL increment pend[issue_waddr] when issue_fire & issue_we & issue_waddr!=0.
REQ-021 SHALL decrement pend[waddr] on every accepted write of REQ-015.
REQ-022 SHALL leave a counter unchanged when increment and decrement hit the same register in the same cycle.
REQ-023 SHALL saturate at 3 on increment and at 0 on decrement, setting pend_err=1 in either case.
REQ-024 SHALL, on sb_clear=1, zero all counters on the next edge, overriding same-cycle increment/decrement.
REQ-025 SHALL assert rsX_busy iff rsX_addr!=0 and pend[rsX_addr]!=0, except deasserted when pend==1 and a same-cycle write to rsX_addr is bypassed.
REQ-026 SHALL increment wr_cnt by 1 per accepted write, wrapping 0xFFFFFFFF -> 0.
REQ-027 SHALL keep pend_err set until reset; sb_clear does not clear it.

Reset
REQ-028 SHALL, while rst=0, clear all registers, counters, pend_err and wr_cnt immediately, independent of clk.
REQ-029 SHALL, while rst=0, drive rs1_data=rs2_data=dbg_data=0, rs1_busy=rs2_busy=0, and suppress bypass, writes and issue.
REQ-030 SHALL discard any write or issue coincident with reset assertion; first write accepted is on the first rising edge after rst=1.

Structure
REQ-031 SHALL take bus width (70), XLEN, NREG and bus field offsets from the shared defines file, not local literals.
REQ-032 SHALL use one sub-module ysyx_2022040010_pend_cnt (one counter with inc/dec/clear/saturate/err), instantiated 31 times.
REQ-033 SHALL keep register array, bypass mux and busy logic in the top module.

Verification
REQ-034 SHALL verify: write x5=0x1234 then read rs1=5 next cycle -> rs1_data=0x1234; write x0=0xFFFF -> rs1_addr=0 reads 0, wr_cnt unchanged.
REQ-035 SHALL verify: same-cycle write x7=0xAA and read rs2=7 -> rs2_data=0xAA that cycle; dbg_addr=7 shows old value until next edge.
REQ-036 SHALL verify: issue x3 -> rs1_addr=3 busy=1; WB writes x3 -> busy=0 that cycle, pend[3]=0 after edge.
REQ-037 SHALL verify: issue x9 four times without writeback -> pend saturates at 3, pend_err=1; sb_clear -> busy=0, pend_err remains 1.
REQ-038 SHALL verify: issue x4 and WB write x4 same cycle with pend[4]=1 -> pend stays 1, rs1_busy (rs1=4) stays 1 next cycle.
REQ-039 SHALL verify: rst=0 mid-cycle after writes -> all reads 0, wr_cnt=0 before next clk edge.

Source files
------------

// File: rtl/ysyx_2022040010_regfile_pkg.sv
// Shared defines for the register file slice.
// Holds the default register geometry and the field layout of the 70-bit
// writeback bus {we, waddr, wdata}, so no module hard-codes these numbers.
package ysyx_2022040010_regfile_pkg;
    localparam int XLEN_D     = 64;  // default register width
    localparam int NREG_D     = 32;  // default architectural register count
    localparam int PEND_W_D   = 2;   // default pending-counter width
    localparam int REG_AW     = 5;   // register address width
    localparam int WB_W       = 70;  // writeback bus width
    localparam int WB_WE_BIT  = 69;  // write enable
    localparam int WB_ADDR_HI = 68;  // write address field
    localparam int WB_ADDR_LO = 64;
    localparam int WB_DATA_LO = 0;   // write data field starts here, XLEN wide
    localparam int WR_CNT_W   = 32;  // committed-write counter width
endpackage

// File: rtl/ysyx_2022040010_regfile_if.sv
// Writeback / issue / scoreboard-clear bundle between the pipeline and the
// register file.
//   wb_to_rf_bus : {we, waddr, wdata} from WB
//   issue_fire, issue_we, issue_waddr : ID issue of a register-writing instr
//   sb_clear     : drop all pending-writer counts (pipeline drained/flushed)
// master = pipeline side, slave = register file side.
interface ysyx_2022040010_regfile_if;
    import ysyx_2022040010_regfile_pkg::*;

    logic [WB_W-1:0]   wb_to_rf_bus;
    logic              issue_fire;
    logic              issue_we;
    logic [REG_AW-1:0] issue_waddr;
    logic              sb_clear;

    modport master (output wb_to_rf_bus, issue_fire, issue_we, issue_waddr, sb_clear);
    modport slave  (input  wb_to_rf_bus, issue_fire, issue_we, issue_waddr, sb_clear);
endinterface

// File: rtl/ysyx_2022040010_pend_cnt.sv
// One saturating pending-writer counter for a single register.
//   clk, rst (async, active-low)
//   inc : an in-flight writer was issued
//   dec : a writer committed
//   clr : synchronous clear, beats inc/dec
//   cnt : current count
//   err : sticky, set on increment at max or decrement at zero (until reset)
module ysyx_2022040010_pend_cnt #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              dec,
    input  logic              clr,
    output logic [PEND_W-1:0] cnt,
    output logic              err
);
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            if (cnt == CNT_MAX) err <= 1'b1;
            else                cnt <= cnt + PEND_W'(1);
        end else if (dec && !inc) begin
            if (cnt == '0) err <= 1'b1;
            else           cnt <= cnt - PEND_W'(1);
        end
        // inc && dec together: one writer in, one out, count unchanged
    end
endmodule

// File: rtl/ysyx_2022040010_regfile.sv
// Integer register file with write-first bypass and a per-register
// pending-writer scoreboard for RAW hazard detection.
//   clk, rst (async, active-low)
//   rf_if             : writeback bus, issue and sb_clear (slave side)
//   rs1/rs2_addr/data : zero-latency ID read ports, bypassed from WB
//   rs1/rs2_busy      : source register still has an outstanding writer
//   dbg_addr/data     : difftest read port, no bypass
//   pend_err          : sticky scoreboard overflow/underflow
//   wr_cnt            : number of committed register writes (wraps)
module ysyx_2022040010_regfile
    import ysyx_2022040010_regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_D,
    parameter int NREG   = NREG_D,
    parameter int PEND_W = PEND_W_D
) (
    input  logic                   clk,
    input  logic                   rst,
    ysyx_2022040010_regfile_if.slave rf_if,
    input  logic [REG_AW-1:0]      rs1_addr,
    input  logic [REG_AW-1:0]      rs2_addr,
    output logic [XLEN-1:0]        rs1_data,
    output logic [XLEN-1:0]        rs2_data,
    output logic                   rs1_busy,
    output logic                   rs2_busy,
    input  logic [REG_AW-1:0]      dbg_addr,
    output logic [XLEN-1:0]        dbg_data,
    output logic                   pend_err,
    output logic [WR_CNT_W-1:0]    wr_cnt
);
    logic              wb_we;
    logic [REG_AW-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              wr_acc;
    logic              iss_acc;

    assign wb_we   = rf_if.wb_to_rf_bus[WB_WE_BIT];
    assign wb_addr = rf_if.wb_to_rf_bus[WB_ADDR_HI:WB_ADDR_LO];
    assign wb_data = rf_if.wb_to_rf_bus[WB_DATA_LO +: XLEN];

    // Qualifying with rst keeps bypass and busy-release quiet while reset is held.
    assign wr_acc  = rst && wb_we && (wb_addr != '0);
    assign iss_acc = rst && rf_if.issue_fire && rf_if.issue_we && (rf_if.issue_waddr != '0);

    // Register array; entry 0 is never written and never read (x0 forced to 0).
    logic [NREG-1:0][XLEN-1:0] regs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs   <= '0;
            wr_cnt <= '0;
        end else if (wr_acc) begin
            regs[wb_addr] <= wb_data;
            wr_cnt        <= wr_cnt + WR_CNT_W'(1);
        end
    end

    // Scoreboard: one counter per register 1..NREG-1.
    logic [NREG-1:0][PEND_W-1:0] pend;
    logic [NREG-1:0]             pend_err_v;

    assign pend[0]       = '0;
    assign pend_err_v[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_pend
        ysyx_2022040010_pend_cnt #(.PEND_W(PEND_W)) u_pend_cnt (
            .clk (clk),
            .rst (rst),
            .inc (iss_acc && (rf_if.issue_waddr == REG_AW'(i))),
            .dec (wr_acc && (wb_addr == REG_AW'(i))),
            .clr (rf_if.sb_clear),
            .cnt (pend[i]),
            .err (pend_err_v[i])
        );
    end

    assign pend_err = |pend_err_v;

    logic hit1, hit2;
    assign hit1 = wr_acc && (wb_addr == rs1_addr);
    assign hit2 = wr_acc && (wb_addr == rs2_addr);

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        dbg_data = '0;
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (rst) begin
            if (rs1_addr != '0) rs1_data = hit1 ? wb_data : regs[rs1_addr];
            if (rs2_addr != '0) rs2_data = hit2 ? wb_data : regs[rs2_addr];
            if (dbg_addr != '0) dbg_data = regs[dbg_addr];
            // The last outstanding writer committing this cycle is already
            // covered by the bypass, so it no longer stalls the reader.
            rs1_busy = (rs1_addr != '0) && (pend[rs1_addr] != '0)
                       && !((pend[rs1_addr] == PEND_W'(1)) && hit1);
            rs2_busy = (rs2_addr != '0) && (pend[rs2_addr] != '0)
                       && !((pend[rs2_addr] == PEND_W'(1)) && hit2);
        end
    end
endmodule

// File: tb/tb_ysyx_2022040010_regfile.sv
module tb_ysyx_2022040010_regfile;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [63:0] wdata = '0;
    logic        issue_fire = 1'b0, issue_we = 1'b0, sb_clear = 1'b0;
    logic [4:0]  issue_waddr = '0;
    logic [4:0]  rs1_addr = '0, rs2_addr = '0, dbg_addr = '0;
    logic [63:0] rs1_data, rs2_data, dbg_data;
    logic        rs1_busy, rs2_busy, pend_err;
    logic [31:0] wr_cnt;

    always #5 clk = ~clk;

    ysyx_2022040010_regfile_if rf_if();
    assign rf_if.wb_to_rf_bus = {we, waddr, wdata};
    assign rf_if.issue_fire   = issue_fire;
    assign rf_if.issue_we     = issue_we;
    assign rf_if.issue_waddr  = issue_waddr;
    assign rf_if.sb_clear     = sb_clear;

    ysyx_2022040010_regfile dut (
        .clk(clk), .rst(rst), .rf_if(rf_if),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .pend_err(pend_err), .wr_cnt(wr_cnt)
    );

    // Reference model: architectural state as plain arrays/integers.
    logic [63:0] m_regs [32];
    int          m_pend [32];
    bit          m_err;
    logic [31:0] m_wrcnt;

    typedef struct {
        logic [63:0] r1, r2, dbg;
        logic        b1, b2, err;
        logic [31:0] wc;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void m_clear();
        for (int r = 0; r < 32; r++) begin m_regs[r] = '0; m_pend[r] = 0; end
        m_err = 1'b0; m_wrcnt = '0;
    endfunction

    // Architectural effect of one clock edge with the currently held inputs.
    function automatic void m_edge();
        bit acc;
        if (!rst) begin m_clear(); return; end
        acc = we && waddr != 0;
        if (acc) begin m_regs[waddr] = wdata; m_wrcnt = m_wrcnt + 1; end
        if (sb_clear) begin
            for (int r = 0; r < 32; r++) m_pend[r] = 0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                bit inc = issue_fire && issue_we && issue_waddr == r;
                bit dec = acc && waddr == r;
                if (inc && !dec) begin
                    if (m_pend[r] == 3) m_err = 1; else m_pend[r]++;
                end else if (dec && !inc) begin
                    if (m_pend[r] == 0) m_err = 1; else m_pend[r]--;
                end
            end
        end
    endfunction

    function automatic logic [63:0] m_read(input logic [4:0] a, input bit bypass);
        if (!rst || a == 0) return '0;
        if (bypass && we && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        bit hit = rst && we && waddr != 0 && waddr == a;
        if (!rst || a == 0 || m_pend[a] == 0) return 1'b0;
        return !(m_pend[a] == 1 && hit);
    endfunction

    task automatic cyc(input bit r, input bit w, input logic [4:0] wa, input logic [63:0] wd,
                       input bit fi, input bit iw, input logic [4:0] ia, input bit clr,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad);
        exp_t e;
        @(posedge clk);
        m_edge();
        #1;
        rst = r; we = w; waddr = wa; wdata = wd;
        issue_fire = fi; issue_we = iw; issue_waddr = ia; sb_clear = clr;
        rs1_addr = a1; rs2_addr = a2; dbg_addr = ad;
        if (!rst) m_clear();
        e.r1  = m_read(a1, 1);
        e.r2  = m_read(a2, 1);
        e.dbg = m_read(ad, 0);
        e.b1  = m_busy(a1);
        e.b2  = m_busy(a2);
        e.err = m_err;
        e.wc  = m_wrcnt;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: mid-cycle, compare whatever the DUT shows against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rs1_data", rs1_data, e.r1);
                chk("rs2_data", rs2_data, e.r2);
                chk("dbg_data", dbg_data, e.dbg);
                chk("rs1_busy", 64'(rs1_busy), 64'(e.b1));
                chk("rs2_busy", 64'(rs2_busy), 64'(e.b2));
                chk("pend_err", 64'(pend_err), 64'(e.err));
                chk("wr_cnt",   64'(wr_cnt),   64'(e.wc));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        m_clear();
        // reset held
        cyc(0, 1, 5, 64'h55, 1, 1, 5, 0, 5, 5, 5);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // write x5, read back; x0 write dropped
        cyc(1, 1, 5, 64'h1234, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 5, 0, 5);
        cyc(1, 1, 0, 64'hFFFF, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // same-cycle bypass on rs2, dbg sees old value until the edge
        cyc(1, 1, 7, 64'hAA, 0, 0, 0, 0, 0, 7, 7);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
        // issue x3, busy, released by WB in the same cycle
        cyc(1, 0, 0, 0, 1, 1, 3, 0, 3, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        cyc(1, 1, 3, 64'h33, 0, 0, 0, 0, 3, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 3);
        // saturate x9, then clear; pend_err stays
        repeat (4) cyc(1, 0, 0, 0, 1, 1, 9, 0, 9, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 9, 9, 0);
        // issue and writeback x4 in the same cycle with one writer pending
        cyc(1, 0, 0, 0, 1, 1, 4, 0, 4, 0, 0);
        cyc(1, 1, 4, 64'h44, 1, 1, 4, 0, 4, 4, 4);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 4, 4, 4);
        // mid-cycle reset after writes
        cyc(1, 1, 12, 64'hC0C0, 0, 0, 0, 0, 12, 0, 12);
        cyc(1, 1, 13, 64'hD0D0, 1, 1, 13, 0, 12, 13, 12);
        cyc(0, 1, 14, 64'hE0E0, 1, 1, 14, 0, 12, 13, 12);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 12, 13, 12);
        // randomized traffic, small address window to force collisions
        for (int i = 0; i < 800; i++) begin
            bit wide = ($urandom_range(0, 9) == 0);
            cyc(($urandom_range(0, 199) != 0),
                $urandom_range(0, 1),
                5'(wide ? $urandom_range(0, 31) : $urandom_range(0, 7)),
                {$urandom, $urandom},
                ($urandom_range(0, 2) == 0), $urandom_range(0, 1),
                5'($urandom_range(0, 7)),
                ($urandom_range(0, 39) == 0),
                5'(wide ? $urandom_range(0, 31) : $urandom_range(0, 7)),
                5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)));
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
